// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, defaults and parameter helpers for sync_fifo_buf
package fifo_pkg;

   localparam int unsigned default_data_width = 8;
   localparam int unsigned default_depth      = 256;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic half_full;
   } fifo_flags_t;

   function automatic bit is_pow2(input int unsigned value);
      return (value != 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - FIFO storage array, synchronous write and asynchronous read, no reset
module sync_fifo_ram
   import fifo_pkg::*;
#(
   parameter int unsigned data_width = default_data_width,
   parameter int unsigned depth      = default_depth,
   parameter int unsigned ptr_width  = $clog2(depth)
) (
   input  logic                  clk,
   input  logic                  w_en,
   input  logic [ptr_width-1:0]  w_addr,
   input  logic [data_width-1:0] w_data,
   input  logic [ptr_width-1:0]  r_addr,
   output logic [data_width-1:0] r_data
);

   logic [data_width-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (w_en) begin
         mem[w_addr] <= w_data;
      end
   end

   assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_buf.sv
// rtl/sync_fifo_buf.sv - single-clock FIFO control: pointers, count, flags, sticky errors
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_buf
   import fifo_pkg::*;
#(
   parameter int unsigned data_width = default_data_width,
   parameter int unsigned depth      = default_depth,
   parameter int unsigned af_level   = 192,
   parameter int unsigned ae_level   = 64,
   parameter int unsigned ptr_width  = $clog2(depth)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_en,
   input  logic [data_width-1:0] data_in,
   input  logic                  r_en,
   input  logic                  clr_err,
   output logic [data_width-1:0] data_out,
   output logic                  r_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  half_full,
   output logic [ptr_width:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   if (!is_pow2(depth) || depth < 4) begin : g_bad_depth
      $error("sync_fifo_buf: depth must be a power of two and at least 4");
   end
   if (af_level < 1 || af_level > depth - 1) begin : g_bad_af
      $error("sync_fifo_buf: af_level must lie in 1..depth-1");
   end
   if (ae_level < 1 || ae_level > depth - 1) begin : g_bad_ae
      $error("sync_fifo_buf: ae_level must lie in 1..depth-1");
   end

   localparam int unsigned      half_level = depth / 2;
   localparam logic [ptr_width:0] depth_cnt = depth[ptr_width:0];
   localparam logic [ptr_width:0] half_cnt  = half_level[ptr_width:0];
   localparam logic [ptr_width:0] af_cnt    = af_level[ptr_width:0];
   localparam logic [ptr_width:0] ae_cnt    = ae_level[ptr_width:0];

   logic [ptr_width-1:0]  wr_ptr;
   logic [ptr_width-1:0]  rd_ptr;
   logic [ptr_width:0]    count_q;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [data_width-1:0] ram_rdata;
   fifo_flags_t           flags;

   always_comb begin
      flags              = '0;
      flags.full         = (count_q == depth_cnt);
      flags.empty        = (count_q == '0);
      flags.almost_full  = (count_q >= af_cnt);
      flags.almost_empty = (count_q <= ae_cnt);
      flags.half_full    = (count_q >= half_cnt);
   end

   // A write into a full FIFO is only safe when a read frees the same slot this cycle.
   assign rd_acc = r_en & ~flags.empty;
   assign wr_acc = w_en & (~flags.full | rd_acc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         overflow  <= (w_en & ~wr_acc) | (overflow & ~clr_err);
         underflow <= (r_en & ~rd_acc) | (underflow & ~clr_err);
      end
   end

   sync_fifo_ram #(
      .data_width (data_width),
      .depth      (depth),
      .ptr_width  (ptr_width)
   ) u_ram (
      .clk    (clk),
      .w_en   (wr_acc),
      .w_addr (wr_ptr),
      .w_data (data_in),
      .r_addr (rd_ptr),
      .r_data (ram_rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = ram_rdata;
   assign r_valid  = ~flags.empty;
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= rd_acc;
         if (rd_acc) begin
            data_out <= ram_rdata;
         end
      end
   end
`endif

   assign full         = flags.full;
   assign empty        = flags.empty;
   assign almost_full  = flags.almost_full;
   assign almost_empty = flags.almost_empty;
   assign half_full    = flags.half_full;
   assign count        = count_q;

endmodule

// File: doc/sync_fifo_buf.md
# sync_fifo_buf

Single-clock, parametrised FIFO buffer: the next generation of the team's FIFO memory for same-domain paths. Holds `depth` words of `data_width` bits and generates its own pointers and occupancy count. Generates full, empty, programmable almost-full/almost-empty, and half-full flags, plus sticky overflow/underflow error flags. Read timing is either registered or first-word-fall-through, selected at compile time.

## Interface
Parameters:
- `data_width`, 8, word width in bits (1..256)
- `depth`, 256, number of words; power of two, at least 4
- `af_level`, 192, `almost_full` asserts when count >= `af_level` (1..`depth`-1)
- `ae_level`, 64, `almost_empty` asserts when count <= `ae_level` (1..`depth`-1)
- `ptr_width`, `$clog2(depth)`, derived; do not override

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `w_en`  in  1  write request
- `data_in`  in  `data_width`  write data
- `r_en`  in  1  read request
- `clr_err`  in  1  synchronous clear of `overflow`/`underflow`
- `data_out`  out  `data_width`  read data
- `r_valid`  out  1  `data_out` holds valid read data
- `full`  out  1  count == `depth`
- `empty`  out  1  count == 0
- `almost_full`  out  1  count >= `af_level`
- `almost_empty`  out  1  count <= `ae_level`
- `half_full`  out  1  count >= `depth`/2
- `count`  out  `ptr_width`+1  current occupancy, 0..`depth`
- `overflow`  out  1  sticky: a write was rejected
- `underflow`  out  1  sticky: a read was rejected

## Operation
- **Read accept:** `rd_acc = r_en & !empty`.
- **Write accept:** `wr_acc = w_en & (!full | rd_acc)`. A write while full is accepted only together with an accepted read.
- **Pointers:** `wr_ptr` and `rd_ptr` are `ptr_width` bits and wrap naturally from `depth`-1 to 0. `wr_ptr` increments on `wr_acc`; `rd_ptr` increments on `rd_acc`.
- **Count:** `count` +1 on write only, −1 on read only, unchanged on both or neither. `count` never leaves 0..`depth`.
- **Flags:** all flags are combinational from the registered `count`. None depends on the current cycle's requests.
- **Error flags:**
  - `overflow` sets on `w_en & !wr_acc`.
  - `underflow` sets on `r_en & !rd_acc`.
  - Both hold until `clr_err` or reset. If set and clear coincide, set wins.
- **Rejected requests:** a rejected write does not modify memory. A rejected read leaves `data_out` and `rd_ptr` unchanged.
- **Storage:** memory contents are not reset. `data_out` is defined only while `r_valid` is high.

## Timing
- **Reset values:**
  - `count`=0, `empty`=1, `almost_empty`=1
  - `full`=0, `almost_full`=0, `half_full`=0
  - `overflow`=0, `underflow`=0
  - `r_valid`=0, `data_out`=0 (registered mode)
  - pointers=0
- **Write latency:** a word accepted in cycle N is readable from cycle N+1, and `count`/`empty` update at edge N+1. There is no write-to-read bypass in the same cycle.
- **Registered mode:** `rd_acc` in cycle N drives `data_out` = mem[`rd_ptr`] and `r_valid`=1 after edge N+1. `r_valid` returns to 0 the next cycle unless another read is accepted. Back-to-back reads give one word per cycle.
- **Boundary conditions:**
  - Empty with `w_en` and `r_en` together: write accepted, read rejected, `underflow` set, `count`→1.
  - Full with `w_en` and `r_en` together: both accepted, `count` stays `depth`, no overflow.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous). In-flight requests are discarded. The first post-reset write goes to address 0.

## Configuration
- **Macro:** `SYNC_FIFO_FWFT_EN`.
- **Defined (FWFT):**
  - `data_out` = mem[`rd_ptr`] combinationally; `r_valid` = `!empty`.
  - `r_en` acknowledges/pops the word currently shown.
  - A word written in cycle N appears on `data_out` in cycle N+1.
- **Undefined:** registered mode as described under Timing. `data_out` is a reset flop.
- Pointer, count, flag and error behaviour are identical in both modes.

## Structure
- **Package `fifo_pkg`:**
  - `fifo_flags_t` packed struct: full, empty, almost_full, almost_empty, half_full.
  - Parameter-check helper function `is_pow2`.
  - Default width and depth constants.
- **Elaboration checks** on `depth`, `af_level` and `ae_level`, reporting `$error` on illegal values.
- **Sub-module `sync_fifo_ram`:** the storage array, with synchronous write port and asynchronous read port. It has no reset and is reused in both read modes.
- **Top level:** the control logic (pointers, count, flags, error flags, output register).

## Test plan
- Reset, then write 0x01..0x04 and read 4 → `data_out` 0x01..0x04 in order. `r_valid` one cycle after each read in registered mode, concurrent in FWFT. `count` 0→4→0.
- Fill with 256 writes (defaults) → `full`=1 and `count`=256. A 257th `w_en` sets `overflow`; memory and `count` are unchanged.
- At `full`, `w_en`+`r_en` for 10 cycles → `count` stays 256, no overflow. Data stays in order across the pointer wrap 255→0.
- Read with `empty`=1 → `underflow`=1, `count` 0. `clr_err` → `underflow` 0 next cycle. Simultaneous `clr_err` and an illegal read → stays 1.
- Sweep occupancy 0→256 → `almost_empty` drops at count 65, `half_full` rises at 128, `almost_full` rises at 192.
- Assert `rst_n` low mid-burst at count 100 → all outputs at reset values immediately. The next write/read returns the new data.
